// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter FSM states
// and the default idle-release timeout.
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int ARB_IDLE_TIMEOUT = 1024;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit
// strictly after prio_ptr, wrapping around.
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] prio_ptr,
    output logic                pick_valid,
    output logic [REQ_BITS-1:0] pick_id
);

    localparam int SW = REQ_BITS + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SW-1:0]        start;
    logic [SW-1:0]        off;
    logic [SW-1:0]        sum;

    always_comb begin
        start      = SW'(prio_ptr) + SW'(1);
        dbl        = {req, req};
        rot        = dbl[start +: NUM_REQ];
        pick_valid = 1'b0;
        off        = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_valid = 1'b1;
                off        = SW'(i);
            end
        end
        sum = start + off;
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        pick_id = sum[REQ_BITS-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing the uart TX
// byte port between requesters, with idle-owner timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = $clog2(NUM_REQ),
    parameter int IDLE_TIMEOUT = ARB_IDLE_TIMEOUT,
    parameter int TO_BITS      = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         data_in,
    output logic                      data_in_valid,
    input  logic                      data_in_ready,
    output logic                      grant_active,
    output logic [REQ_BITS-1:0]       grant_id,
    output logic                      timeout_pulse
);

    localparam int CW = (TO_BITS > 0) ? TO_BITS : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(IDLE_TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [REQ_BITS-1:0] gid_q, gid_d;
    logic [REQ_BITS-1:0] ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tp_q, tp_d;

    logic                pick_valid;
    logic [REQ_BITS-1:0] pick_id;
    logic                own_valid;
    logic                own_last;
    logic [BYTE_W-1:0]   own_data;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_picker (
        .req        (req_valid),
        .prio_ptr   (ptr_q),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    assign own_valid = req_valid[gid_q];
    assign own_last  = req_last[gid_q];
    assign own_data  = req_data[gid_q*BYTE_W +: BYTE_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gid_q   <= '0;
            ptr_q   <= REQ_BITS'(NUM_REQ - 1);
            cnt_q   <= '0;
            tp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tp_q    <= tp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tp_d    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    gid_d   = pick_id;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // A present byte always beats the idle timeout.
                if (own_valid) begin
                    cnt_d = '0;
                    if (data_in_ready && own_last) begin
                        state_d = ARB_IDLE;
                        ptr_d   = gid_q;
                    end
                end else if (IDLE_TIMEOUT != 0) begin
                    if (cnt_q == TO_LAST) begin
                        state_d = ARB_IDLE;
                        ptr_d   = gid_q;
                        tp_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        data_in       = '0;
        data_in_valid = 1'b0;
        if (state_q == ARB_LOCK) begin
            data_in          = own_data;
            data_in_valid    = own_valid;
            req_ready[gid_q] = data_in_ready;
        end
    end

    assign grant_active  = (state_q == ARB_LOCK);
    assign grant_id      = gid_q;
    assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester
// streams, round-robin message model, handshake monitor.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     data_in;
    logic           data_in_valid;
    logic           data_in_ready;
    logic           grant_active;
    logic [1:0]     grant_id;
    logic           timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         gap;
        logic [7:0] b;
        logic       last;
    } item_t;

    typedef struct {
        int         id;
        logic [7:0] b;
        logic       last;
    } exp_t;

    item_t src[N][$];
    item_t mdl[N][$];
    exp_t  sb[$];
    int    m_ptr;
    int    rdy_mode;
    int    tests;
    int    fails;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_src(input int i, input int gap,
                           input logic [7:0] b, input logic last);
        item_t t;
        t.gap = gap;
        t.b = b;
        t.last = last;
        src[i].push_back(t);
    endtask

    task automatic push_item(input int i, input int gap,
                             input logic [7:0] b, input logic last);
        item_t t;
        t.gap = gap;
        t.b = b;
        t.last = last;
        src[i].push_back(t);
        mdl[i].push_back(t);
    endtask

    task automatic push_sb(input int id, input logic [7:0] b,
                           input logic last);
        exp_t e;
        e.id = id;
        e.b = b;
        e.last = last;
        sb.push_back(e);
    endtask

    // Whole messages leave in round-robin order after m_ptr.
    task automatic run_model();
        bit    found;
        item_t t;
        do begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && mdl[i].size() > 0) begin
                    found = 1'b1;
                    do begin
                        t = mdl[i].pop_front();
                        push_sb(i, t.b, t.last);
                    end while (!t.last && mdl[i].size() > 0);
                    m_ptr = i;
                end
            end
        end while (found);
    endtask

    task automatic wait_ga(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_active !== 1'b1 && n < 50);
        check(nm, grant_active, 1);
    endtask

    task automatic drain(input string nm, input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || grant_active) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(nm, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            src[i].delete();
            mdl[i].delete();
        end
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ptr = N - 1;
    endtask

    // Requester and uart-ready driver.
    initial begin
        logic [N-1:0] hs;
        item_t        t;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        data_in_ready = 1'b1;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            if (reset) hs = '0;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src[i].size() > 0) t = src[i].pop_front();
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                if (src[i].size() > 0) begin
                    t = src[i][0];
                    if (t.gap > 0) begin
                        t.gap--;
                        src[i][0] = t;
                    end else begin
                        req_valid[i] = 1'b1;
                        req_last[i] = t.last;
                        req_data[i*8 +: 8] = t.b;
                    end
                end
            end
            case (rdy_mode)
                1: data_in_ready = ~data_in_ready;
                2: data_in_ready = 1'($urandom_range(0, 1));
                default: data_in_ready = 1'b1;
            endcase
        end
    end

    // Monitor: ready routing, idle outputs, handshake scoreboard.
    initial begin
        logic [N-1:0] exp_rdy;
        exp_t         e;
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            if (grant_active && data_in_ready) exp_rdy[grant_id] = 1'b1;
            check("ready_vec", req_ready, exp_rdy);
            if (!grant_active) check("idle_out", {data_in_valid, data_in}, 0);
            if (data_in_valid && data_in_ready) begin
                if (sb.size() == 0) begin
                    check("sb_extra", {grant_id, data_in}, 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_byte", data_in, e.b);
                    check("sb_id", grant_id, e.id);
                    check("sb_last", req_last[grant_id], e.last);
                end
            end
        end
    end

    initial begin
        int n;
        int idle;
        int tpc;
        tests = 0;
        fails = 0;
        rdy_mode = 0;
        m_ptr = N - 1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_data", data_in, 0);
        check("rst_valid", data_in_valid, 0);
        check("rst_active", grant_active, 0);
        check("rst_gid", grant_id, 0);
        check("rst_pulse", timeout_pulse, 0);
        reset = 1'b0;

        // Single requester, 3-byte message.
        @(negedge clk);
        push_item(2, 0, 8'h41, 1'b0);
        push_item(2, 0, 8'h42, 1'b0);
        push_item(2, 0, 8'h43, 1'b1);
        run_model();
        wait_ga("t1_grant", n);
        check("t1_latency", n, 2);
        check("t1_gid", grant_id, 2);
        for (int k = 0; k < 3; k++) begin
            check("t1_hs", data_in_valid & data_in_ready, 1);
            @(negedge clk);
        end
        check("t1_release", grant_active, 0);
        drain("t1_drain", 50);

        // All requesters busy with single-byte messages.
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++)
                push_item(i, 0, 8'(8'h60 + i * 2 + j), 1'b1);
        run_model();
        for (int k = 0; k < 2 * N; k++) begin
            wait_ga("t2_grant", n);
            if (k > 0) check("t2_gap", n, 2);
            check("t2_order", grant_id, k % N);
        end
        drain("t2_drain", 50);

        // Owner stalls mid-message and is released by timeout.
        @(negedge clk);
        add_src(1, 0, 8'h10, 1'b0);
        push_sb(1, 8'h10, 1'b0);
        add_src(2, 0, 8'h20, 1'b1);
        push_sb(2, 8'h20, 1'b1);
        wait_ga("t3_grant", n);
        check("t3_gid", grant_id, 1);
        n = 0;
        idle = 0;
        tpc = 0;
        while (grant_active && n < 60) begin
            if (!data_in_valid) idle++;
            if (timeout_pulse) tpc++;
            @(negedge clk);
            n++;
        end
        check("t3_idle_cycles", idle, TO);
        check("t3_early_pulse", tpc, 0);
        check("t3_pulse", timeout_pulse, 1);
        @(negedge clk);
        check("t3_pulse_width", timeout_pulse, 0);
        check("t3_next_grant", grant_active, 1);
        check("t3_next_gid", grant_id, 2);
        drain("t3_drain", 50);
        m_ptr = 2;

        // Valid returns exactly when the count would expire.
        @(negedge clk);
        push_item(3, 0, 8'h30, 1'b0);
        push_item(3, TO - 1, 8'h31, 1'b0);
        push_item(3, TO - 1, 8'h32, 1'b1);
        run_model();
        wait_ga("t4_grant", n);
        n = 0;
        tpc = 0;
        while (grant_active && n < 60) begin
            if (timeout_pulse) tpc++;
            @(negedge clk);
            n++;
        end
        check("t4_lock_len", n, 3 + 2 * (TO - 1));
        check("t4_no_timeout", tpc + timeout_pulse, 0);
        drain("t4_drain", 50);

        // Toggling uart ready with other requesters waiting.
        @(negedge clk);
        rdy_mode = 1;
        for (int k = 0; k < 4; k++)
            push_item(3, 0, 8'(8'h80 + k), k == 3);
        run_model();
        wait_ga("t5_grant", n);
        check("t5_gid", grant_id, 3);
        push_item(0, 0, 8'h90, 1'b1);
        push_item(1, 0, 8'h91, 1'b1);
        run_model();
        drain("t5_drain", 100);
        rdy_mode = 0;

        // Reset in the middle of a message from requester 0.
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            add_src(0, 0, 8'(8'h70 + k), k == 3);
        push_sb(0, 8'h70, 1'b0);
        wait_ga("t6_grant", n);
        check("t6_gid", grant_id, 0);
        push_item(3, 0, 8'hA3, 1'b1);
        push_item(2, 0, 8'hA2, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_data", data_in, 0);
        check("t6_rst_valid", data_in_valid, 0);
        check("t6_rst_active", grant_active, 0);
        check("t6_rst_gid", grant_id, 0);
        check("t6_rst_pulse", timeout_pulse, 0);
        check("t6_sb", sb.size(), 0);
        src[0].delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ptr = N - 1;
        run_model();
        wait_ga("t6_regrant", n);
        check("t6_lowest", grant_id, 2);
        drain("t6_drain", 50);

        // Randomized traffic with random uart ready.
        rdy_mode = 2;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                int nm;
                nm = int'($urandom_range(0, 3));
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = int'($urandom_range(1, 5));
                    for (int b = 0; b < len; b++)
                        push_item(i, 0, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            run_model();
            drain("rand_drain", 2000);
        end
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        check("final_sb", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
